colormem_multi: RTL and testbench

//  NCHAN-bank colour lookup memory (one bank per playfield), each bank DWIDTH x 2**AWIDTH BRAM.

---
 rtl/colormem_multi.sv | 173 +++++++++++++++++
 tb/tb_colormem_multi.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/colormem_multi.sv
// Multi-bank colour lookup memory with a shared host write port and a fill engine
// that clears every bank after reset. Define COLORMEM_RDBACK_EN to add a host read-back port.
`timescale 1ns/1ps

module colormem_multi #(
  parameter int              AWIDTH     = 8,
  parameter int              DWIDTH     = 16,
  parameter int              NCHAN      = 2,
  parameter logic [DWIDTH-1:0] RESET_FILL = '0,
  localparam int             CW         = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
  input  logic                      clk,
  input  logic                      reset_i,
  input  logic [NCHAN-1:0]          rd_en_i,
  input  logic [NCHAN*AWIDTH-1:0]   rd_addr_i,
  output logic [NCHAN*DWIDTH-1:0]   rd_data_o,
  input  logic                      wr_en_i,
  input  logic [CW-1:0]             wr_chan_i,
  input  logic [AWIDTH-1:0]         wr_addr_i,
  input  logic [DWIDTH-1:0]         wr_data_i,
  output logic                      wr_ready_o,
  input  logic                      fill_start_i,
  input  logic [CW-1:0]             fill_chan_i,
  input  logic [DWIDTH-1:0]         fill_data_i,
`ifdef COLORMEM_RDBACK_EN
  input  logic                      rb_req_i,
  input  logic [CW-1:0]             rb_chan_i,
  input  logic [AWIDTH-1:0]         rb_addr_i,
  output logic [DWIDTH-1:0]         rb_data_o,
  output logic                      rb_valid_o,
`endif
  output logic                      busy_o
);

  localparam int DEPTH = 2 ** AWIDTH;
  localparam logic [AWIDTH:0] LAST = {1'b0, {AWIDTH{1'b1}}};

  typedef enum logic [1:0] {IDLE, CLEAR_ALL, FILL_ONE} state_t;

  state_t              state_q, state_d;
  logic [AWIDTH:0]     cnt_q, cnt_d;
  logic [CW-1:0]       fill_chan_q, fill_chan_d;
  logic [DWIDTH-1:0]   fill_data_q, fill_data_d;

  logic [NCHAN-1:0]    bank_we;
  logic [AWIDTH-1:0]   wr_addr;
  logic [DWIDTH-1:0]   wr_word;

  logic [DWIDTH-1:0]   mem [NCHAN][DEPTH];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q     <= CLEAR_ALL;
      cnt_q       <= '0;
      fill_chan_q <= '0;
      fill_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fill_chan_q <= fill_chan_d;
      fill_data_q <= fill_data_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fill_chan_d = fill_chan_q;
    fill_data_d = fill_data_q;
    bank_we     = '0;
    wr_addr     = wr_addr_i;
    wr_word     = wr_data_i;
    busy_o      = 1'b1;
    wr_ready_o  = 1'b0;

    unique case (state_q)
      IDLE: begin
        busy_o     = 1'b0;
        wr_ready_o = 1'b1;
        // Out-of-range channels match no bank, so the write is simply dropped.
        for (int k = 0; k < NCHAN; k++)
          bank_we[k] = wr_en_i && (wr_chan_i == CW'(k));
        if (fill_start_i) begin
          state_d     = FILL_ONE;
          fill_chan_d = fill_chan_i;
          fill_data_d = fill_data_i;
          cnt_d       = '0;
        end
      end
      CLEAR_ALL: begin
        bank_we = '1;
        wr_addr = cnt_q[AWIDTH-1:0];
        wr_word = RESET_FILL;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      FILL_ONE: begin
        for (int k = 0; k < NCHAN; k++)
          bank_we[k] = (fill_chan_q == CW'(k));
        wr_addr = cnt_q[AWIDTH-1:0];
        wr_word = fill_data_q;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = CLEAR_ALL;
    endcase

    if (reset_i) begin
      bank_we    = '0;
      busy_o     = 1'b1;
      wr_ready_o = 1'b0;
    end
  end

  // NOTE: the memory array is deliberately not reset; the clear engine initialises it.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NCHAN; k++)
      if (bank_we[k]) mem[k][wr_addr] <= wr_word;
  end

`ifdef COLORMEM_RDBACK_EN
  logic [NCHAN-1:0]  rb_grant;
  logic              rb_pend_q;
  logic [CW-1:0]     rb_chan_q;
  logic [DWIDTH-1:0] rb_raw [NCHAN];

  // Read-back borrows a bank's read port only in cycles where video leaves it idle.
  always_comb begin
    rb_grant = '0;
    for (int k = 0; k < NCHAN; k++)
      rb_grant[k] = rb_req_i && !rb_pend_q && !rb_valid_o && !reset_i &&
                    !rd_en_i[k] && (rb_chan_i == CW'(k));
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      rb_pend_q  <= 1'b0;
      rb_chan_q  <= '0;
      rb_valid_o <= 1'b0;
      rb_data_o  <= '0;
    end else begin
      rb_pend_q  <= |rb_grant;
      rb_valid_o <= rb_pend_q;
      if (|rb_grant) rb_chan_q <= rb_chan_i;
      if (rb_pend_q) rb_data_o <= rb_raw[rb_chan_q];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset_i) begin
      rd_data_o <= '0;
    end else begin
      for (int k = 0; k < NCHAN; k++) begin
        if (rd_en_i[k])
          rd_data_o[k*DWIDTH +: DWIDTH] <= mem[k][rd_addr_i[k*AWIDTH +: AWIDTH]];
`ifdef COLORMEM_RDBACK_EN
        else if (rb_grant[k])
          rb_raw[k] <= mem[k][rb_addr_i];
`endif
      end
    end
  end

endmodule

// File: tb/tb_colormem_multi.sv
// Scoreboard bench for colormem_multi: reads push expected words, a negedge monitor pops and compares.
`timescale 1ns/1ps

module tb_colormem_multi;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int NC = 2;

  logic              clk = 1'b0;
  logic              reset_i;
  logic [NC-1:0]     rd_en_i;
  logic [NC*AW-1:0]  rd_addr_i;
  logic [NC*DW-1:0]  rd_data_o;
  logic              wr_en_i;
  logic [0:0]        wr_chan_i;
  logic [AW-1:0]     wr_addr_i;
  logic [DW-1:0]     wr_data_i;
  logic              wr_ready_o;
  logic              fill_start_i;
  logic [0:0]        fill_chan_i;
  logic [DW-1:0]     fill_data_i;
  logic              busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] exp_q0 [$];
  logic [DW-1:0] exp_q1 [$];
  logic [NC-1:0] rd_seen = '0;

  always #5 clk = ~clk;

  colormem_multi #(.AWIDTH(AW), .DWIDTH(DW), .NCHAN(NC), .RESET_FILL(16'h0000)) dut (
    .clk          (clk),
    .reset_i      (reset_i),
    .rd_en_i      (rd_en_i),
    .rd_addr_i    (rd_addr_i),
    .rd_data_o    (rd_data_o),
    .wr_en_i      (wr_en_i),
    .wr_chan_i    (wr_chan_i),
    .wr_addr_i    (wr_addr_i),
    .wr_data_i    (wr_data_i),
    .wr_ready_o   (wr_ready_o),
    .fill_start_i (fill_start_i),
    .fill_chan_i  (fill_chan_i),
    .fill_data_i  (fill_data_i),
    .busy_o       (busy_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a read issued at a posedge is compared at the following negedge.
  always @(posedge clk) rd_seen <= rd_en_i & {NC{~reset_i}};

  always @(negedge clk) begin
    if (rd_seen[0]) begin
      if (exp_q0.size() == 0) check("rd0_unexpected", 32'd1, 32'd0);
      else check("rd_data bank0", 32'(rd_data_o[DW-1:0]), 32'(exp_q0.pop_front()));
    end
    if (rd_seen[1]) begin
      if (exp_q1.size() == 0) check("rd1_unexpected", 32'd1, 32'd0);
      else check("rd_data bank1", 32'(rd_data_o[2*DW-1:DW]), 32'(exp_q1.pop_front()));
    end
  end

  task automatic do_read(input int bank, input logic [AW-1:0] addr, input logic [DW-1:0] exp);
    @(posedge clk); #1;
    rd_en_i = '0;
    rd_en_i[bank] = 1'b1;
    rd_addr_i[bank*AW +: AW] = addr;
    if (bank == 0) exp_q0.push_back(exp);
    else exp_q1.push_back(exp);
    @(posedge clk); #1;
    rd_en_i = '0;
  endtask

  // Drives the request immediately and holds it until wr_ready_o; returns cycles waited.
  task automatic host_write(input logic ch, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data, output int waits);
    wr_en_i = 1'b1; wr_chan_i = ch; wr_addr_i = addr; wr_data_i = data;
    waits = 0;
    while (waits < 2000) begin
      @(negedge clk);
      if (wr_ready_o) break;
      waits++;
    end
    @(posedge clk); #1;
    wr_en_i = 1'b0;
  endtask

  // Counts negedges with busy_o high (bounded); also counts wr_ready_o leaks while busy.
  task automatic count_busy(output int n, output int rdy);
    n = 0; rdy = 0;
    while (n < 2000) begin
      @(negedge clk);
      if (!busy_o) break;
      if (wr_ready_o) rdy++;
      n++;
    end
  endtask

  initial begin
    int n, rdy, waits;
    reset_i = 1'b1; rd_en_i = '0; rd_addr_i = '0;
    wr_en_i = 1'b0; wr_chan_i = '0; wr_addr_i = '0; wr_data_i = '0;
    fill_start_i = 1'b0; fill_chan_i = '0; fill_data_i = '0;

    // Reset and post-reset clear
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", 32'(busy_o), 32'd1);
    check("reset wr_ready", 32'(wr_ready_o), 32'd0);
    check("reset rd_data", 32'(rd_data_o), 32'd0);
    @(posedge clk); #1 reset_i = 1'b0;
    count_busy(n, rdy);
    check("clear busy cycles", 32'(n), 32'd256);
    check("clear wr_ready leak", 32'(rdy), 32'd0);
    do_read(0, 8'hFF, 16'h0000);
    do_read(1, 8'hFF, 16'h0000);

    // Host write in IDLE
    @(negedge clk);
    host_write(1'b1, 8'h10, 16'h0F0F, waits);
    check("idle write wait", 32'(waits), 32'd0);
    do_read(1, 8'h10, 16'h0F0F);
    do_read(0, 8'h10, 16'h0000);

    // Fill bank0 while a host write is held pending
    @(posedge clk); #1;
    fill_start_i = 1'b1; fill_chan_i = 1'b0; fill_data_i = 16'hABCD;
    @(posedge clk); #1;
    fill_start_i = 1'b0;
    host_write(1'b0, 8'h20, 16'h7777, waits);
    check("fill wr_ready low cycles", 32'(waits), 32'd256);
    do_read(0, 8'h20, 16'h7777);
    do_read(0, 8'h00, 16'hABCD);
    do_read(0, 8'h1F, 16'hABCD);
    do_read(0, 8'hFF, 16'hABCD);
    do_read(1, 8'h10, 16'h0F0F);

    // Same-cycle write + fill on bank1; a second fill_start mid-fill is ignored
    @(posedge clk); #1;
    wr_en_i = 1'b1; wr_chan_i = 1'b1; wr_addr_i = 8'h05; wr_data_i = 16'h1234;
    fill_start_i = 1'b1; fill_chan_i = 1'b1; fill_data_i = 16'h5555;
    @(negedge clk);
    check("same-cycle wr_ready", 32'(wr_ready_o), 32'd1);
    @(posedge clk); #1;
    wr_en_i = 1'b0; fill_start_i = 1'b0;
    n = 0;
    while (n < 2000) begin
      @(negedge clk);
      fill_start_i = 1'b0;
      if (!busy_o) break;
      n++;
      if (n == 50) begin
        fill_start_i = 1'b1; fill_chan_i = 1'b0; fill_data_i = 16'h9999;
      end
    end
    check("fill busy cycles", 32'(n), 32'd256);
    do_read(1, 8'h05, 16'h5555);
    do_read(1, 8'h10, 16'h5555);
    do_read(0, 8'h00, 16'hABCD);
    do_read(0, 8'h20, 16'h7777);

    // Reset in the middle of a fill restarts the clear from address 0
    @(posedge clk); #1;
    fill_start_i = 1'b1; fill_chan_i = 1'b0; fill_data_i = 16'h1111;
    @(posedge clk); #1;
    fill_start_i = 1'b0;
    repeat (100) @(posedge clk);
    #1 reset_i = 1'b1;
    @(negedge clk);
    check("midfill reset busy", 32'(busy_o), 32'd1);
    check("midfill reset wr_ready", 32'(wr_ready_o), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midfill reset rd_data", 32'(rd_data_o), 32'd0);
    @(posedge clk); #1 reset_i = 1'b0;
    count_busy(n, rdy);
    check("reclear busy cycles", 32'(n), 32'd256);
    check("reclear wr_ready leak", 32'(rdy), 32'd0);
    do_read(0, 8'h00, 16'h0000);
    do_read(0, 8'h63, 16'h0000);
    do_read(0, 8'h64, 16'h0000);
    do_read(0, 8'hFF, 16'h0000);
    do_read(1, 8'h05, 16'h0000);

    repeat (3) @(posedge clk);
    check("scoreboard drained", 32'(exp_q0.size() + exp_q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
